tsp_2opt: RTL

TSP_2OPT -- requirements
Module: tsp_2opt

---
 rtl/tsp_2opt_if.sv | 32 +++
 rtl/tsp_2opt.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tsp_2opt_if.sv
// Coordinate load, run control and result signals of the tsp_2opt 2-opt tour optimiser.
interface tsp_2opt_if #(
    parameter int N_CITY  = 64,
    parameter int COORD_W = 16,
    parameter int ITER_W  = 32
);
    localparam int IDX_W  = $clog2(N_CITY);
    localparam int COST_W = COORD_W + 2 + IDX_W;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               start;
    logic [ITER_W-1:0]  iter_limit;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   rd_city;
    logic               busy;
    logic               done;
    logic [COST_W-1:0]  cost;
    logic [ITER_W-1:0]  accepted;

    modport master (
        output wr_en, wr_idx, wr_x, wr_y, start, iter_limit, rd_idx,
        input  rd_city, busy, done, cost, accepted
    );

    modport slave (
        input  wr_en, wr_idx, wr_x, wr_y, start, iter_limit, rd_idx,
        output rd_city, busy, done, cost, accepted
    );
endinterface

// File: rtl/tsp_2opt.sv
// Randomised 2-opt improvement of a cyclic tour over Manhattan distances.
// The tour is rebuilt as the identity on every start; path[0] is never moved.
module tsp_2opt #(
    parameter int          N_CITY  = 64,
    parameter int          COORD_W = 16,
    parameter int          ITER_W  = 32,
    parameter logic [31:0] SEED    = 32'h2545F491
) (
    input logic       clk,
    input logic       rst,
    tsp_2opt_if.slave bus
);
    localparam int IDX_W  = $clog2(N_CITY);
    localparam int COST_W = COORD_W + 2 + IDX_W;
    localparam int DIST_W = COORD_W + 1;
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(N_CITY - 1);
    localparam logic [IDX_W-1:0]  ONE     = IDX_W'(1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    typedef enum logic [2:0] {IDLE, INIT, COST, PICK, EVAL, REV, DONE} state_t;

    function automatic logic [DIST_W-1:0] manhattan(
        input logic [COORD_W-1:0] xa, input logic [COORD_W-1:0] ya,
        input logic [COORD_W-1:0] xb, input logic [COORD_W-1:0] yb);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = (xa > xb) ? xa - xb : xb - xa;
        dy = (ya > yb) ? ya - yb : yb - ya;
        return DIST_W'(dx) + DIST_W'(dy);
    endfunction

    function automatic logic signed [COST_W:0] to_signed(input logic [DIST_W-1:0] d);
        return signed'({{(COST_W + 1 - DIST_W){1'b0}}, d});
    endfunction

    function automatic logic [31:0] xorshift(input logic [31:0] s);
        logic [31:0] x;
        x = s ^ (s << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [IDX_W-1:0] draw(input logic [31:0] r);
        return IDX_W'((r % 32'(N_CITY - 1)) + 32'd1);
    endfunction

    function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] p);
        return (p == LAST) ? '0 : p + ONE;
    endfunction

    logic [COORD_W-1:0] xs_q   [N_CITY];
    logic [COORD_W-1:0] ys_q   [N_CITY];
    logic [IDX_W-1:0]   path_q [N_CITY];

    state_t             state_q, state_d;
    logic [COST_W-1:0]  cost_q, cost_d;
    logic [ITER_W-1:0]  accepted_q, accepted_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [31:0]        rnd_q, rnd_d;
    logic [ITER_W-1:0]  limit_q, limit_d;
    logic [COST_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]   a_q, a_d;
    logic               have_a_q, have_a_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
    logic [IDX_W-1:0]   lo_q, lo_d, hi_q, hi_d;

    logic               coord_we;
    logic               p0_we, p1_we;
    logic [IDX_W-1:0]   p0_idx, p0_val, p1_idx, p1_val;
    logic [IDX_W-1:0]   pick;
    logic [COST_W-1:0]  acc_sum;

    // Edge lengths for the tour sum and for the 2-opt move under evaluation
    logic [IDX_W-1:0]   c_k, c_k1, c_im1, c_i, c_j, c_jp1;
    logic [DIST_W-1:0]  d_tour, d_new_a, d_new_b, d_old_a, d_old_b;
    logic signed [COST_W:0] delta;
    logic signed [COST_W:0] cost_sum;

    assign c_k   = path_q[k_q];
    assign c_k1  = path_q[succ(k_q)];
    assign c_im1 = path_q[i_q - ONE];
    assign c_i   = path_q[i_q];
    assign c_j   = path_q[j_q];
    assign c_jp1 = path_q[succ(j_q)];

    assign d_tour  = manhattan(xs_q[c_k],   ys_q[c_k],   xs_q[c_k1],  ys_q[c_k1]);
    assign d_new_a = manhattan(xs_q[c_im1], ys_q[c_im1], xs_q[c_j],   ys_q[c_j]);
    assign d_new_b = manhattan(xs_q[c_i],   ys_q[c_i],   xs_q[c_jp1], ys_q[c_jp1]);
    assign d_old_a = manhattan(xs_q[c_im1], ys_q[c_im1], xs_q[c_i],   ys_q[c_i]);
    assign d_old_b = manhattan(xs_q[c_j],   ys_q[c_j],   xs_q[c_jp1], ys_q[c_jp1]);

    assign delta    = to_signed(d_new_a) + to_signed(d_new_b)
                    - to_signed(d_old_a) - to_signed(d_old_b);
    assign cost_sum = signed'({1'b0, cost_q}) + delta;
    assign acc_sum  = acc_q + COST_W'(d_tour);
    assign pick     = draw(rnd_q);

    always_comb begin
        state_d    = state_q;
        cost_d     = cost_q;
        accepted_d = accepted_q;
        iter_d     = iter_q;
        rnd_d      = rnd_q;
        limit_d    = limit_q;
        acc_d      = acc_q;
        k_d        = k_q;
        a_d        = a_q;
        have_a_d   = have_a_q;
        i_d        = i_q;
        j_d        = j_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        coord_we   = 1'b0;
        p0_we      = 1'b0;
        p0_idx     = lo_q;
        p0_val     = path_q[hi_q];
        p1_we      = 1'b0;
        p1_idx     = hi_q;
        p1_val     = path_q[lo_q];

        if (state_q != IDLE && state_q != DONE) begin
            rnd_d = xorshift(rnd_q);
        end

        case (state_q)
            IDLE, DONE: begin
                coord_we = bus.wr_en;
                if (bus.start) begin
                    state_d    = INIT;
                    k_d        = '0;
                    accepted_d = '0;
                    iter_d     = '0;
                    limit_d    = bus.iter_limit;
                end
            end
            INIT: begin
                p0_we  = 1'b1;
                p0_idx = k_q;
                p0_val = k_q;
                k_d    = succ(k_q);
                if (k_q == LAST) begin
                    state_d = COST;
                    acc_d   = '0;
                end
            end
            COST: begin
                acc_d = acc_sum;
                k_d   = succ(k_q);
                if (k_q == LAST) begin
                    cost_d   = acc_sum;
                    have_a_d = 1'b0;
                    state_d  = (limit_q == '0) ? DONE : PICK;
                end
            end
            PICK: begin
                if (!have_a_q) begin
                    a_d      = pick;
                    have_a_d = 1'b1;
                end else if (pick != a_q) begin
                    i_d     = (pick < a_q) ? pick : a_q;
                    j_d     = (pick < a_q) ? a_q : pick;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                iter_d   = iter_q + ITER_ONE;
                have_a_d = 1'b0;
                if (delta[COST_W]) begin
                    cost_d  = cost_sum[COST_W-1:0];
                    lo_d    = i_q;
                    hi_d    = j_q;
                    state_d = REV;
                end else begin
                    state_d = (iter_d == limit_q) ? DONE : PICK;
                end
            end
            REV: begin
                p0_we = 1'b1;
                p1_we = 1'b1;
                lo_d  = lo_q + ONE;
                hi_d  = hi_q - ONE;
                if (lo_d >= hi_d) begin
                    accepted_d = accepted_q + ITER_ONE;
                    state_d    = (iter_q == limit_q) ? DONE : PICK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cost_q     <= '0;
            accepted_q <= '0;
            iter_q     <= '0;
            rnd_q      <= SEED;
        end else begin
            state_q    <= state_d;
            cost_q     <= cost_d;
            accepted_q <= accepted_d;
            iter_q     <= iter_d;
            rnd_q      <= rnd_d;
        end
        limit_q  <= limit_d;
        acc_q    <= acc_d;
        k_q      <= k_d;
        a_q      <= a_d;
        have_a_q <= have_a_d;
        i_q      <= i_d;
        j_q      <= j_d;
        lo_q     <= lo_d;
        hi_q     <= hi_d;
    end

    // Storage is deliberately outside reset: coordinates and tour survive rst
    always_ff @(posedge clk) begin
        if (coord_we) begin
            xs_q[bus.wr_idx] <= bus.wr_x;
            ys_q[bus.wr_idx] <= bus.wr_y;
        end
        if (p0_we) path_q[p0_idx] <= p0_val;
        if (p1_we) path_q[p1_idx] <= p1_val;
    end

    assign bus.rd_city  = path_q[bus.rd_idx];
    assign bus.busy     = (state_q inside {INIT, COST, PICK, EVAL, REV});
    assign bus.done     = (state_q == DONE);
    assign bus.cost     = cost_q;
    assign bus.accepted = accepted_q;
endmodule
